fetch_unit: RTL and testbench

Instruction fetch stage that produces the 16-bit instruction words whose opcode field [15:12] feeds the control decoder.
- Issues word-addressed requests to instruction memory and captures each returned word.
- Presents the word to decode through a valid/ready handshake.
- Applies branch/jump redirects from execute, discarding any stale in-flight fetch.

---
 rtl/isa_pkg.sv | 28 ++
 rtl/fetch_perf_cnt.sv | 37 +++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings and instruction field positions
// used by the fetch stage and the control decoder.
package isa_pkg;

  // Opcode field position inside a 16-bit instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  // Opcode encodings seen by the control decoder
  localparam logic [3:0] OP_TYPEA = 4'b1111;
  localparam logic [3:0] OP_ANDI  = 4'b1000;
  localparam logic [3:0] OP_ORI   = 4'b1001;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_SB    = 4'b1011;
  localparam logic [3:0] OP_LB    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0001;
  localparam logic [3:0] OP_HALT  = 4'b0000;

  // Extract the opcode field from an instruction word
  function automatic logic [3:0] get_opcode(input logic [15:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counters for the fetch stage: completed transfers
// to decode and discarded memory responses. Only instantiated when
// FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_fetch_inc,
  input  logic        i_squash_inc,
  output logic [31:0] o_fetch_count,
  output logic [15:0] o_squash_count
);

  logic [31:0] r_fetch_count;
  logic [15:0] r_squash_count;

  // Count accepted instructions, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= '0;
    end else if (i_fetch_inc && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Count discarded responses, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_squash_count <= '0;
    end else if (i_squash_inc && (r_squash_count != '1)) begin
      r_squash_count <= r_squash_count + 16'd1;
    end
  end

  assign o_fetch_count  = r_fetch_count;
  assign o_squash_count = r_squash_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one word-addressed request at a time,
// captures the response and offers it to decode via valid/ready. Redirects
// from execute replace the pc and discard any stale response in flight.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / squash_count.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic            if_valid,
  input  logic            dec_ready,
  output logic [15:0]     if_instr,
  output logic [3:0]      if_opcode,
  output logic [PC_W-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [15:0]     squash_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            r_drop;
  logic            w_drop_next;
  logic [15:0]     r_instr;
  logic [15:0]     w_instr_next;
  logic [PC_W-1:0] r_if_pc;
  logic [PC_W-1:0] w_if_pc_next;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_instr <= '0;
      r_if_pc <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_drop  <= w_drop_next;
      r_instr <= w_instr_next;
      r_if_pc <= w_if_pc_next;
    end
  end

  // Next-state logic; a redirect takes priority over every normal transition
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_instr_next = r_instr;
    w_if_pc_next = r_if_pc;

    if (redirect_valid) begin
      w_pc_next = redirect_pc;
      case (r_state)
        S_IDLE, S_HOLD: w_state_next = S_REQ;
        // The request leaves this cycle with the old pc, so its answer is stale
        S_REQ: begin
          w_drop_next  = 1'b1;
          w_state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            // Response arriving now is stale; nothing else is outstanding
            w_drop_next  = 1'b0;
            w_state_next = S_REQ;
          end else begin
            w_drop_next  = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_REQ;
        S_REQ:  w_state_next = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (r_drop) begin
              w_drop_next  = 1'b0;
              w_state_next = S_REQ;
            end else begin
              w_instr_next = imem_rdata;
              w_if_pc_next = r_pc;
              w_pc_next    = r_pc + PC_W'(1);
              w_state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            w_state_next = S_REQ;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = (r_state == S_REQ) ? r_pc : '0;
  assign if_valid  = (r_state == S_HOLD);
  assign if_instr  = r_instr;
  assign if_opcode = get_opcode(r_instr);
  assign if_pc     = r_if_pc;

`ifdef FETCH_PERF_CNT_EN
  logic w_accept;
  logic w_discard;

  assign w_accept  = (r_state == S_HOLD) && dec_ready && !redirect_valid;
  assign w_discard = (r_state == S_WAIT) && imem_valid && (r_drop || redirect_valid);

  fetch_perf_cnt u_perf_cnt (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_fetch_inc    (w_accept),
    .i_squash_inc   (w_discard),
    .o_fetch_count  (fetch_count),
    .o_squash_count (squash_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, basic fetch, decode stall, the
// redirect cases and pc wrap (second instance with RESET_PC=16'hFFFF).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;

  // Main instance (RESET_PC = 0)
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic        dec_ready;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [15:0] if_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  // Wrap instance (RESET_PC = 0xFFFF)
  logic        imem_req_b;
  logic [15:0] imem_addr_b;
  logic        imem_valid_b;
  logic [15:0] imem_rdata_b;
  logic        if_valid_b;
  logic        dec_ready_b;
  logic [15:0] if_instr_b;
  logic [3:0]  if_opcode_b;
  logic [15:0] if_pc_b;
  logic        redirect_valid_b;
  logic [15:0] redirect_pc_b;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] squash_count;
  logic [31:0] fetch_count_b;
  logic [15:0] squash_count_b;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];
  int          mem_lat;
  int          cnt;
  logic [15:0] addr_q;

  logic [15:0] log_b [0:1];
  int          n_b;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .dec_ready      (dec_ready),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .squash_count   (squash_count)
`endif
  );

  fetch_unit #(.PC_W(16), .RESET_PC(16'hFFFF)) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req_b),
    .imem_addr      (imem_addr_b),
    .imem_valid     (imem_valid_b),
    .imem_rdata     (imem_rdata_b),
    .if_valid       (if_valid_b),
    .dec_ready      (dec_ready_b),
    .if_instr       (if_instr_b),
    .if_opcode      (if_opcode_b),
    .if_pc          (if_pc_b),
    .redirect_valid (redirect_valid_b),
    .redirect_pc    (redirect_pc_b)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count_b),
    .squash_count   (squash_count_b)
`endif
  );

  // Memory model for the main instance: one response per request, mem_lat cycles later
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_valid <= 1'b0;
      imem_rdata <= 16'h0000;
      cnt        <= 0;
      addr_q     <= 16'h0000;
    end else begin
      imem_valid <= 1'b0;
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem[addr_q[7:0]];
        end
      end
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem[imem_addr[7:0]];
        end else begin
          cnt    <= mem_lat - 1;
          addr_q <= imem_addr;
        end
      end
    end
  end

  // Latency-1 memory for the wrap instance, plus a log of its first two addresses
  assign imem_rdata_b = 16'h0000;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_valid_b <= 1'b0;
      n_b          <= 0;
    end else begin
      imem_valid_b <= imem_req_b;
      if (imem_req_b && n_b < 2) begin
        log_b[n_b] <= imem_addr_b;
        n_b        <= n_b + 1;
      end
    end
  end

  // One line per completed transfer to decode
  always @(posedge clk) begin
    if (reset_n && if_valid && dec_ready && !redirect_valid)
      $display("xfer pc=%04h instr=%04h opcode=%h", if_pc, if_instr, if_opcode);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!if_valid && k < 30) begin
      step();
      k++;
    end
    total++;
    if (if_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: if_valid=%b after %0d cycles, expected 1", tag, if_valid, k);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    mem_lat        = 1;
    repeat (3) step();
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL rst_req: req=%b addr=%h, expected 0/0000", imem_req, imem_addr);
    end
    total++;
    if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000) begin
      bad++;
      $display("FAIL rst_out: valid=%b instr=%h pc=%h, expected 0/0000/0000", if_valid, if_instr, if_pc);
    end
    reset_n = 1'b1;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h, expected 1/0000", imem_req, imem_addr);
    end
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid: if_valid=%b, expected 0", if_valid);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_opcode !== 4'hF || if_pc !== 16'h0000 || if_instr !== 16'hF123) begin
      bad++;
      $display("FAIL first_instr: valid=%b op=%h pc=%h instr=%h, expected 1/f/0000/f123",
               if_valid, if_opcode, if_pc, if_instr);
    end
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL second_req: req=%b addr=%h valid=%b, expected 1/0001/0", imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_hold_stall();
    dec_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (if_valid !== 1'b1 || imem_req !== 1'b0 || if_instr !== 16'h8055 ||
          if_pc !== 16'h0001 || if_opcode !== 4'h8) begin
        bad++;
        $display("FAIL stall_%0d: valid=%b req=%b instr=%h pc=%h op=%h, expected 1/0/8055/0001/8",
                 i, if_valid, imem_req, if_instr, if_pc, if_opcode);
      end
      step();
    end
    dec_ready = 1'b1;
    step();
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, expected 0/1/0002", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int k = 0;
    bit saw = 1'b0;
    mem_lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    while (!imem_req && k < 10) begin
      if (if_valid) saw = 1'b1;
      step();
      k++;
    end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL rw_stale: if_valid=1 seen, expected 0 while stale response drains");
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL rw_target: req=%b addr=%h, expected 1/0040", imem_req, imem_addr);
    end
    wait_valid("rw");
    total++;
    if (if_instr !== 16'h4321 || if_pc !== 16'h0040) begin
      bad++;
      $display("FAIL rw_instr: instr=%h pc=%h, expected 4321/0040", if_instr, if_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    int k = 0;
    while (!imem_valid && k < 15) begin
      step();
      k++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    step();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      bad++;
      $display("FAIL rc_target: valid=%b req=%b addr=%h, expected 0/1/0080", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    wait_valid("rh");
    total++;
    if (if_instr !== 16'h4A5B || if_pc !== 16'h0080) begin
      bad++;
      $display("FAIL rh_instr: instr=%h pc=%h, expected 4a5b/0080", if_instr, if_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    step();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      bad++;
      $display("FAIL rh_squash: valid=%b req=%b addr=%h, expected 0/1/0010", if_valid, imem_req, imem_addr);
    end
    wait_valid("rh2");
    total++;
    if (if_instr !== 16'h6C0D || if_pc !== 16'h0010) begin
      bad++;
      $display("FAIL rh_target: instr=%h pc=%h, expected 6c0d/0010", if_instr, if_pc);
    end
  endtask

  task automatic test_redirect_req();
    int k = 0;
    bit saw = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0011) begin
      bad++;
      $display("FAIL rq_req: req=%b addr=%h, expected 1/0011", imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    step();
    redirect_valid = 1'b0;
    while (!imem_req && k < 10) begin
      if (if_valid) saw = 1'b1;
      step();
      k++;
    end
    total++;
    if (saw || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
      bad++;
      $display("FAIL rq_target: stale_valid=%b req=%b addr=%h, expected 0/1/0020", saw, imem_req, imem_addr);
    end
    wait_valid("rq");
    total++;
    if (if_instr !== 16'h5E0F || if_pc !== 16'h0020) begin
      bad++;
      $display("FAIL rq_instr: instr=%h pc=%h, expected 5e0f/0020", if_instr, if_pc);
    end
    step();
    dec_ready = 1'b0;
  endtask

  task automatic test_perf_counters();
    repeat (8) step();
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (fetch_count !== 32'd5) begin
      bad++;
      $display("FAIL fetch_count: got %0d, expected 5", fetch_count);
    end
    total++;
    if (squash_count !== 16'd3) begin
      bad++;
      $display("FAIL squash_count: got %0d, expected 3", squash_count);
    end
`endif
  endtask

  task automatic test_pc_wrap();
    total++;
    if (n_b < 2 || log_b[0] !== 16'hFFFF || log_b[1] !== 16'h0000) begin
      bad++;
      $display("FAIL pc_wrap: n=%0d addr0=%h addr1=%h, expected 2/ffff/0000", n_b, log_b[0], log_b[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'hF123;
    mem[8'h01] = 16'h8055;
    mem[8'h02] = 16'h9A0B;
    mem[8'h10] = 16'h6C0D;
    mem[8'h11] = 16'hD00E;
    mem[8'h20] = 16'h5E0F;
    mem[8'h21] = 16'h0000;
    mem[8'h40] = 16'h4321;
    mem[8'h41] = 16'h1ABC;
    mem[8'h80] = 16'h4A5B;
    dec_ready_b      = 1'b1;
    redirect_valid_b = 1'b0;
    redirect_pc_b    = 16'h0000;

    test_reset();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_hold();
    test_redirect_req();
    test_perf_counters();
    test_pc_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
